// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU-side memory responders: instruction width,
// reset PC, the response pipeline stage layout and the wait-state LFSR taps.
package cpu_mem_pkg;

    localparam int          INST_WIDTH = 32;
    localparam logic [31:0] RESET_PC   = 32'hbfc00000;

    // Fibonacci taps 16,14,13,11 expressed as a bit mask over lfsr[15:0].
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    typedef struct packed {
        logic                  valid;
        logic                  err;
        logic [INST_WIDTH-1:0] data;
    } resp_stage_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/inst_resp_pipe.sv
// LATENCY-deep shift register of {valid, err, data}. The stage written at
// acceptance is stage 0; the last stage drives the response outputs.
module inst_resp_pipe
    import cpu_mem_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  resp_stage_t in_stage,
    output resp_stage_t out_stage
);

    resp_stage_t stage_q [LATENCY];

    // Shift one stage per cycle; reset drops everything in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= in_stage;
            for (int i = 1; i < LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign out_stage = stage_q[LATENCY-1];

endmodule

// File: rtl/inst_sram_responder.sv
// Instruction-SRAM responder for the fetch stage: accepts a PC, returns the
// word from an internal array after LATENCY cycles, in order, one per cycle.
// Optional macro INST_SRAM_RANDOM_DELAY_EN adds LFSR-driven wait states on
// addr_ok; without it addr_ok is high whenever reset is released.
module inst_sram_responder
    import cpu_mem_pkg::*;
#(
    parameter int          DEPTH     = 4096,
    parameter int          LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = RESET_PC,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int         AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  inst_sram_en,
    input  logic [31:0]           inst_sram_addr,
    output logic                  inst_sram_addr_ok,
    output logic [INST_WIDTH-1:0] inst_sram_rdata,
    output logic                  inst_sram_data_ok,
    output logic                  inst_sram_err,
    input  logic                  ld_we,
    input  logic [AW-1:0]         ld_addr,
    input  logic [INST_WIDTH-1:0] ld_wdata
);

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("inst_sram_responder: LATENCY must be 1..4");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("inst_sram_responder: LFSR_SEED must be non-zero");
    end
    if ((1 << AW) != DEPTH) begin : g_bad_depth
        $error("inst_sram_responder: DEPTH must be a power of two");
    end

    logic [INST_WIDTH-1:0] mem [DEPTH];
    logic [31:0]           offset;
    logic [AW-1:0]         rd_index;
    logic                  misaligned;
    logic                  accept;
    resp_stage_t           in_stage;
    resp_stage_t           out_stage;

`ifdef INST_SRAM_RANDOM_DELAY_EN
    logic [15:0] lfsr_q;

    // Free-running wait-state generator; reloads the seed on reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign inst_sram_addr_ok = resetn & (lfsr_q[1:0] != 2'b00);
`else
    // Ready from the very first cycle after release, so no register stage.
    assign inst_sram_addr_ok = resetn;
`endif

    // Out-of-window addresses simply wrap: only the low index bits matter.
    assign offset     = inst_sram_addr - BASE_ADDR;
    assign rd_index   = AW'(offset >> 2);
    assign misaligned = |inst_sram_addr[1:0];
    assign accept     = inst_sram_en & inst_sram_addr_ok;

    // Loader port; the array itself is deliberately not reset.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ld_addr] <= ld_wdata;
        end
    end

    // Read at acceptance; the pipe register samples before the loader write
    // lands, which gives read-before-write on a same-index collision.
    always_comb begin
        in_stage       = '0;
        in_stage.valid = accept;
        in_stage.err   = accept & misaligned;
        if (accept && !misaligned) begin
            in_stage.data = mem[rd_index];
        end
    end

    inst_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk       (clk),
        .resetn    (resetn),
        .in_stage  (in_stage),
        .out_stage (out_stage)
    );

    // Empty stages carry zero data, so rdata idles at zero.
    assign inst_sram_data_ok = out_stage.valid;
    assign inst_sram_err     = out_stage.err;
    assign inst_sram_rdata   = out_stage.data;

endmodule
